// File: rtl/spi_cs_seq.sv
// ---------------------------------------------------------------------------
// spi_cs_seq: frames multi-byte SPI transfers under one chip select, paces
// bytes into a byte-level master, enforces a CS gap. Option: SPI_CS_TIMEOUT_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_cs_seq #(
  parameter int MAX_BYTES_PER_CS = 2,
  parameter int CS_INACTIVE_CLKS = 100,
  parameter int TIMEOUT_CLKS     = 1000,
  localparam int CNT_W = $clog2(MAX_BYTES_PER_CS + 1)
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic [CNT_W-1:0] i_TX_Count,
  input  logic [7:0]       i_TX_Byte,
  input  logic             i_TX_DV,
  output logic             o_TX_Ready,
  output logic [CNT_W-1:0] o_RX_Count,
  output logic             o_RX_DV,
  output logic [7:0]       o_RX_Byte,
  output logic [7:0]       o_M_TX_Byte,
  output logic             o_M_TX_DV,
  input  logic             i_M_TX_Ready,
  input  logic             i_M_RX_DV,
  input  logic [7:0]       i_M_RX_Byte,
  output logic             o_SPI_CS_n,
  output logic             o_Timeout
);

  localparam int GAP_W = (CS_INACTIVE_CLKS > 1) ? $clog2(CS_INACTIVE_CLKS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t           state_q;
  logic             cs_n_q;
  logic             m_tx_dv_q;
  logic [7:0]       m_tx_byte_q;
  logic             rx_dv_q;
  logic [7:0]       rx_byte_q;
  logic [CNT_W-1:0] rx_count_q;
  logic [CNT_W-1:0] remaining_q;
  logic             inflight_q;
  logic [GAP_W-1:0] gap_cnt_q;

  logic             w_xfer_ready;
  logic [CNT_W-1:0] w_count_clamped;

`ifdef SPI_CS_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  logic [TMO_W-1:0] tmo_cnt_q;
  logic             timeout_q;
`endif

  // The cycle carrying o_M_TX_DV is excluded: the master has not yet dropped its ready.
  assign w_xfer_ready = (state_q == ST_XFER) && (remaining_q != '0) && !inflight_q
                        && i_M_TX_Ready && !m_tx_dv_q;
  assign o_TX_Ready   = i_Rst_L && ((state_q == ST_IDLE) || w_xfer_ready);

  assign w_count_clamped = (i_TX_Count > CNT_W'(MAX_BYTES_PER_CS)) ?
                           CNT_W'(MAX_BYTES_PER_CS) : i_TX_Count;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_q     <= ST_IDLE;
      cs_n_q      <= 1'b1;
      m_tx_dv_q   <= 1'b0;
      m_tx_byte_q <= 8'h00;
      rx_dv_q     <= 1'b0;
      rx_byte_q   <= 8'h00;
      rx_count_q  <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
      gap_cnt_q   <= '0;
`ifdef SPI_CS_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      m_tx_dv_q <= 1'b0;
      rx_dv_q   <= 1'b0;
`ifdef SPI_CS_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      // Index advances after the pulse so o_RX_DV carries the byte's own index.
      if (rx_dv_q) begin
        rx_count_q <= rx_count_q + CNT_W'(1);
      end

      case (state_q)
        ST_IDLE: begin
          if (i_TX_DV && (i_TX_Count != '0)) begin
            remaining_q <= w_count_clamped;
            m_tx_byte_q <= i_TX_Byte;
            m_tx_dv_q   <= 1'b1;
            inflight_q  <= 1'b1;
            rx_count_q  <= '0;
            cs_n_q      <= 1'b0;
            state_q     <= ST_XFER;
`ifdef SPI_CS_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
          end
        end

        ST_XFER: begin
          if (i_M_RX_DV && (remaining_q != '0)) begin
            rx_byte_q   <= i_M_RX_Byte;
            rx_dv_q     <= 1'b1;
            remaining_q <= remaining_q - CNT_W'(1);
            inflight_q  <= 1'b0;
          end else if (i_TX_DV && w_xfer_ready) begin
            m_tx_byte_q <= i_TX_Byte;
            m_tx_dv_q   <= 1'b1;
            inflight_q  <= 1'b1;
`ifdef SPI_CS_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
          end else if ((remaining_q == '0) && !inflight_q && i_M_TX_Ready) begin
            cs_n_q    <= 1'b1;
            gap_cnt_q <= '0;
            state_q   <= ST_GAP;
`ifdef SPI_CS_TIMEOUT_EN
          end else if (w_xfer_ready) begin
            if (tmo_cnt_q == TMO_W'(TIMEOUT_CLKS - 1)) begin
              timeout_q   <= 1'b1;
              tmo_cnt_q   <= '0;
              remaining_q <= '0;
              cs_n_q      <= 1'b1;
              gap_cnt_q   <= '0;
              state_q     <= ST_GAP;
            end else begin
              tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
            end
`endif
          end
        end

        ST_GAP: begin
          if (gap_cnt_q == GAP_W'(CS_INACTIVE_CLKS - 1)) begin
            state_q <= ST_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + GAP_W'(1);
          end
        end

        default: begin
          state_q <= ST_IDLE;
          cs_n_q  <= 1'b1;
        end
      endcase
    end
  end

  assign o_SPI_CS_n  = cs_n_q;
  assign o_M_TX_DV   = m_tx_dv_q;
  assign o_M_TX_Byte = m_tx_byte_q;
  assign o_RX_DV     = rx_dv_q;
  assign o_RX_Byte   = rx_byte_q;
  assign o_RX_Count  = rx_count_q;

`ifdef SPI_CS_TIMEOUT_EN
  assign o_Timeout = timeout_q;
`else
  assign o_Timeout = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_cs_seq.sv
// ---------------------------------------------------------------------------
// tb_spi_cs_seq: self-checking bench for spi_cs_seq with a behavioural SPI master
// and transaction-level expectations. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_spi_cs_seq;

  localparam int MAXB = 2;
  localparam int GAP  = 100;
  localparam int TMO  = 20;
  localparam int CW   = $clog2(MAXB + 1);

  logic          clk = 1'b0;
  logic          rst_l;
  logic [CW-1:0] i_TX_Count;
  logic [7:0]    i_TX_Byte;
  logic          i_TX_DV;
  logic          o_TX_Ready;
  logic [CW-1:0] o_RX_Count;
  logic          o_RX_DV;
  logic [7:0]    o_RX_Byte;
  logic [7:0]    o_M_TX_Byte;
  logic          o_M_TX_DV;
  logic          i_M_TX_Ready;
  logic          i_M_RX_DV;
  logic [7:0]    i_M_RX_Byte;
  logic          o_SPI_CS_n;
  logic          o_Timeout;

  always #5 clk = ~clk;

  spi_cs_seq #(
    .MAX_BYTES_PER_CS(MAXB),
    .CS_INACTIVE_CLKS(GAP),
    .TIMEOUT_CLKS    (TMO)
  ) dut (
    .i_Clk       (clk),
    .i_Rst_L     (rst_l),
    .i_TX_Count  (i_TX_Count),
    .i_TX_Byte   (i_TX_Byte),
    .i_TX_DV     (i_TX_DV),
    .o_TX_Ready  (o_TX_Ready),
    .o_RX_Count  (o_RX_Count),
    .o_RX_DV     (o_RX_DV),
    .o_RX_Byte   (o_RX_Byte),
    .o_M_TX_Byte (o_M_TX_Byte),
    .o_M_TX_DV   (o_M_TX_DV),
    .i_M_TX_Ready(i_M_TX_Ready),
    .i_M_RX_DV   (i_M_RX_DV),
    .i_M_RX_Byte (i_M_RX_Byte),
    .o_SPI_CS_n  (o_SPI_CS_n),
    .o_Timeout   (o_Timeout)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_tx[$];
  logic [7:0] exp_rxb[$];
  int         exp_rxi[$];
  int         rx_idx, m_rx_cnt, rx_seen, m_lat, m_rdy_wait;
  logic [7:0] m_resp, last_tx;
  bit         loopback;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: monitor DUT outputs against expectation queues, then advance the master model.
  task automatic step();
    @(posedge clk);
    #1;
    if (o_M_TX_DV) begin
      if (exp_tx.size() == 0) chk("m_tx_unexpected", o_M_TX_DV, 1'b0);
      else begin
        last_tx = exp_tx.pop_front();
        chk("m_tx_byte", o_M_TX_Byte, last_tx);
      end
    end
    if (o_RX_DV) begin
      rx_seen++;
      if (exp_rxb.size() == 0) chk("rx_unexpected", o_RX_DV, 1'b0);
      else begin
        chk("rx_byte", o_RX_Byte, exp_rxb.pop_front());
        chk("rx_count", o_RX_Count, exp_rxi.pop_front());
      end
    end
`ifndef SPI_CS_TIMEOUT_EN
    if (o_Timeout !== 1'b0) chk("timeout_disabled", o_Timeout, 1'b0);
`endif
    if (i_M_RX_DV) begin
      i_M_RX_DV  = 1'b0;
      m_rdy_wait = $urandom_range(1, 3);
    end else if (m_rdy_wait > 0) begin
      m_rdy_wait--;
      if (m_rdy_wait == 0) i_M_TX_Ready = 1'b1;
    end
    if (o_M_TX_DV) begin
      i_M_TX_Ready = 1'b0;
      m_lat        = $urandom_range(2, 6);
      m_resp       = loopback ? last_tx : 8'($urandom);
    end else if (m_lat > 0) begin
      m_lat--;
      if (m_lat == 0) begin
        i_M_RX_DV   = 1'b1;
        i_M_RX_Byte = m_resp;
        exp_rxb.push_back(m_resp);
        exp_rxi.push_back(rx_idx);
        rx_idx++;
        m_rx_cnt++;
      end
    end
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    while (!o_TX_Ready && k < 500) begin
      step();
      k++;
    end
    chk(tag, o_TX_Ready, 1'b1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_TX_Byte = b;
    i_TX_DV   = 1'b1;
    exp_tx.push_back(b);
    step();
    i_TX_DV = 1'b0;
  endtask

  task automatic do_txn(input int cnt, input logic [7:0] b0, input logic [7:0] b1,
                        input bit hold, input bit poke_gap);
    int n, sent, k, gap;
    bit aborted;
    n = (cnt > MAXB) ? MAXB : cnt;
    wait_ready("idle_ready");
    rx_idx = 0; rx_seen = 0; m_rx_cnt = 0; sent = 0; aborted = 0;
    i_TX_Count = CW'(cnt);
    if (n == 0) begin
      i_TX_Byte = b0;
      i_TX_DV   = 1'b1;
      step();
      i_TX_DV = 1'b0;
      chk("zero_cs", o_SPI_CS_n, 1'b1);
      chk("zero_ready", o_TX_Ready, 1'b1);
      repeat (3) step();
      chk("zero_cs_later", o_SPI_CS_n, 1'b1);
      return;
    end
    send_byte(b0);
    sent = 1;
    chk("cs_fall", o_SPI_CS_n, 1'b0);
    chk("m_tx_dv_after_accept", o_M_TX_DV, 1'b1);
    chk("ready_low_after_accept", o_TX_Ready, 1'b0);
    k = 0;
    while (rx_seen < n && !aborted && k < 2000) begin
      chk("cs_low_in_txn", o_SPI_CS_n, 1'b0);
      if (sent > m_rx_cnt) chk("ready_low_inflight", o_TX_Ready, 1'b0);
      if (o_TX_Ready && sent < n) begin
        if (hold && sent == 1) begin
`ifdef SPI_CS_TIMEOUT_EN
          int t = 0;
          while (!o_Timeout && t < TMO + 10) begin
            step();
            t++;
          end
          chk("timeout_delay", t, TMO);
          chk("timeout_cs_high", o_SPI_CS_n, 1'b1);
          aborted = 1;
`else
          repeat (3 * TMO) step();
          chk("hold_cs_low", o_SPI_CS_n, 1'b0);
          chk("hold_no_timeout", o_Timeout, 1'b0);
`endif
        end
        if (!aborted) begin
          repeat ($urandom_range(0, 2)) step();
          chk("ready_held", o_TX_Ready, 1'b1);
          send_byte(b1);
          sent++;
        end
      end else begin
        step();
        k++;
      end
    end
    if (!aborted) begin
      chk("txn_rx_all", rx_seen, n);
      chk("cs_low_after_last_rx", o_SPI_CS_n, 1'b0);
    end
    k = 0;
    while (o_SPI_CS_n == 1'b0 && k < 20) begin
      step();
      k++;
    end
    chk("cs_rise", o_SPI_CS_n, 1'b1);
    gap = 0;
    while (!o_TX_Ready && gap < GAP + 20) begin
      if (o_SPI_CS_n !== 1'b1) chk("cs_high_in_gap", o_SPI_CS_n, 1'b1);
      if (poke_gap && gap == 3) begin
        i_TX_Count = CW'(1);
        i_TX_Byte  = 8'h5A;
        i_TX_DV    = 1'b1;
      end
      step();
      i_TX_DV = 1'b0;
      gap++;
    end
    chk("gap_len", gap, GAP);
  endtask

  initial begin
    rst_l = 1'b0; i_TX_Count = '0; i_TX_Byte = 8'h00; i_TX_DV = 1'b0;
    i_M_TX_Ready = 1'b1; i_M_RX_DV = 1'b0; i_M_RX_Byte = 8'h00;
    m_lat = 0; m_rdy_wait = 0; rx_idx = 0; m_rx_cnt = 0; rx_seen = 0;
    m_resp = 8'h00; last_tx = 8'h00; loopback = 1'b1;

    repeat (2) step();
    chk("rst_cs", o_SPI_CS_n, 1'b1);
    chk("rst_ready", o_TX_Ready, 1'b0);
    chk("rst_m_tx_dv", o_M_TX_DV, 1'b0);
    chk("rst_rx_dv", o_RX_DV, 1'b0);
    chk("rst_timeout", o_Timeout, 1'b0);
    chk("rst_rx_count", o_RX_Count, 0);
    chk("rst_rx_byte", o_RX_Byte, 8'h00);
    chk("rst_m_tx_byte", o_M_TX_Byte, 8'h00);
    rst_l = 1'b1;
    step();
    chk("ready_after_rst", o_TX_Ready, 1'b1);

    do_txn(1, 8'hA5, 8'h00, 1'b0, 1'b0);
    do_txn(2, 8'h3C, 8'hC3, 1'b0, 1'b1);
    do_txn(0, 8'h11, 8'h22, 1'b0, 1'b0);
    loopback = 1'b0;
    do_txn(3, 8'h96, 8'h69, 1'b0, 1'b0);
    do_txn(2, 8'hE1, 8'h1E, 1'b1, 1'b0);

    // Reset while the first byte is still inside the master.
    wait_ready("rst_idle_ready");
    rx_idx = 0; m_rx_cnt = 0;
    i_TX_Count = CW'(2);
    send_byte(8'h77);
    chk("midrst_cs_low", o_SPI_CS_n, 1'b0);
    step();
    rst_l = 1'b0;
    m_lat = 0; m_rdy_wait = 0; i_M_RX_DV = 1'b0; i_M_TX_Ready = 1'b1;
    exp_rxb.delete(); exp_rxi.delete(); exp_tx.delete();
    step();
    chk("midrst_cs_high", o_SPI_CS_n, 1'b1);
    chk("midrst_ready_low", o_TX_Ready, 1'b0);
    chk("midrst_rx_count", o_RX_Count, 0);
    rst_l = 1'b1;
    step();
    chk("post_rst_cs", o_SPI_CS_n, 1'b1);
    chk("post_rst_ready", o_TX_Ready, 1'b1);
    rx_seen = 0;
    repeat (20) step();
    chk("no_rx_after_rst", rx_seen, 0);

    for (int i = 0; i < 10; i++) begin
      loopback = 1'($urandom_range(0, 1));
      do_txn($urandom_range(0, 3), 8'($urandom), 8'($urandom), 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_cs_seq.md
Name: spi_cs_seq

Overview:
- Transaction sequencer between a host-side byte stream and the byte-level SPI master.
- Frames a multi-byte transfer under one active-low chip select.
- Paces the bytes into the master and tags each returned byte with its index.
- Enforces a minimum CS-inactive gap between transactions; the master itself is untouched.

Parameters:
- MAX_BYTES_PER_CS, 2, maximum bytes per transaction; CNT_W = $clog2(MAX_BYTES_PER_CS+1).
- CS_INACTIVE_CLKS, 100, i_Clk cycles CS is held high after a transaction ends (min 1).
- TIMEOUT_CLKS, 1000, inter-byte host timeout; only used with SPI_CS_TIMEOUT_EN.

Ports:
- i_Clk  in  1  system clock.
- i_Rst_L  in  1  reset; one clock, synchronous, active-low.
- i_TX_Count  in  CNT_W  bytes in transaction; sampled only on the IDLE-state accept.
- i_TX_Byte  in  8  host byte.
- i_TX_DV  in  1  host byte valid; accepted only while o_TX_Ready=1.
- o_TX_Ready  out  1  sequencer can take a byte.
- o_RX_Count  out  CNT_W  index of current o_RX_Byte within the transaction.
- o_RX_DV  out  1  one-cycle pulse, received byte valid.
- o_RX_Byte  out  8  received byte.
- o_M_TX_Byte  out  8  to master i_TX_Byte.
- o_M_TX_DV  out  1  to master i_TX_DV, one-cycle pulse.
- i_M_TX_Ready  in  1  from master o_TX_Ready.
- i_M_RX_DV  in  1  from master o_RX_DV.
- i_M_RX_Byte  in  8  from master o_RX_Byte.
- o_SPI_CS_n  out  1  chip select, active-low.
- o_Timeout  out  1  one-cycle abort pulse; constant 0 without SPI_CS_TIMEOUT_EN.

Behaviour:
- Reset values (synchronous, i_Rst_L=0 at a rising i_Clk edge):
  - State IDLE, o_SPI_CS_n=1, o_TX_Ready=0 for the reset cycle and then 1.
  - o_M_TX_DV=0, o_RX_DV=0, o_Timeout=0.
  - o_RX_Count=0, o_RX_Byte=0, o_M_TX_Byte=0, remaining count=0, in-flight flag=0.
- Mid-operation reset: CS goes high at that edge and the transaction is dropped. The master is reset separately.
- States:
  - IDLE: o_TX_Ready=1, CS high. On i_TX_DV with i_TX_Count!=0:
    - latch remaining=i_TX_Count and o_M_TX_Byte=i_TX_Byte;
    - clear o_RX_Count;
    - set in-flight; go to XFER.
    - Next cycle: o_SPI_CS_n=0, o_M_TX_DV=1 (one cycle), o_TX_Ready=0.
    - i_TX_DV with i_TX_Count=0 is ignored: stay IDLE, CS high.
  - XFER, o_SPI_CS_n=0:
    - i_M_RX_DV: o_RX_Byte<=i_M_RX_Byte, o_RX_DV pulses next cycle with the current o_RX_Count, then o_RX_Count increments. Also decrement remaining and clear in-flight.
    - o_TX_Ready=1 only when remaining!=0, in-flight=0, i_M_TX_Ready=1, and no o_M_TX_DV in the current cycle.
    - Host i_TX_DV while ready: latch byte, set in-flight, pulse o_M_TX_DV next cycle. CS stays low between bytes.
    - remaining=0, in-flight=0, i_M_TX_Ready=1: go to CS_GAP; CS high next cycle.
  - CS_GAP: CS high, o_TX_Ready=0, count CS_INACTIVE_CLKS cycles, then IDLE.
- Latencies:
  - Host accept to o_M_TX_DV: 1 cycle.
  - Master RX_DV to o_RX_DV: 1 cycle.
  - Last RX_DV to CS high: at least 2 cycles (waits for master ready).
- i_TX_DV while o_TX_Ready=0 is ignored with no side effects.
- Simultaneous i_M_RX_DV and host i_TX_DV cannot occur in XFER, because ready requires in-flight=0.
- i_TX_Count > MAX_BYTES_PER_CS is clamped to MAX_BYTES_PER_CS.
- o_RX_Count wraps within CNT_W only if it exceeds MAX, which is unreachable.

Optional Feature:
- SPI_CS_TIMEOUT_EN defined:
  - In XFER with remaining!=0 and in-flight=0, a counter runs while o_TX_Ready=1 and i_TX_DV=0. It clears on each accepted byte.
  - On reaching TIMEOUT_CLKS: o_Timeout pulses 1 cycle, CS goes high, enter CS_GAP. Remaining bytes are discarded.
- Not defined: no counter; XFER waits for the host indefinitely; o_Timeout tied 0.

Test Plan:
- Reset then single byte: i_TX_Count=1, i_TX_Byte=8'hA5, loopback MISO=MOSI.
  - o_SPI_CS_n falls 1 cycle after accept; o_M_TX_DV one pulse with 8'hA5.
  - o_RX_DV once with o_RX_Byte=8'hA5, o_RX_Count=0.
  - CS high and stays high exactly CS_INACTIVE_CLKS cycles, then o_TX_Ready=1.
- Two bytes 8'h3C, 8'hC3 (count=2):
  - CS continuously low across both bytes.
  - o_RX_DV with counts 0 then 1.
  - o_TX_Ready low while a byte is in flight.
- Protocol errors:
  - i_TX_Count=0: no CS activity, o_TX_Ready stays 1.
  - i_TX_DV while o_TX_Ready=0 (during CS_GAP): no o_M_TX_DV, no state change.
- Reset asserted mid-byte in XFER: o_SPI_CS_n=1 and o_TX_Ready=1 one cycle after reset release; o_RX_DV never pulses.
- With SPI_CS_TIMEOUT_EN, TIMEOUT_CLKS=20, count=2, second byte withheld: o_Timeout pulses 20 cycles after ready, then CS high and CS_GAP.
- Without SPI_CS_TIMEOUT_EN, same stimulus: CS stays low indefinitely and o_Timeout stays 0.
